// File: rtl/otter_icache_pkg.sv
// rtl/otter_icache_pkg.sv - shared state type and address-split width helpers for otter_icache
package otter_icache_pkg;

  typedef enum logic [0:0] {
    READY = 1'b0,
    FILL  = 1'b1
  } state_e;

  // Address split: [tag | index | word | byte offset]
  function automatic int wb_of(input int words_per_line);
    return $clog2(words_per_line);
  endfunction

  function automatic int ib_of(input int lines);
    return $clog2(lines);
  endfunction

  function automatic int tb_of(input int lines, input int words_per_line);
    return 30 - $clog2(words_per_line) - $clog2(lines);
  endfunction

endpackage

// File: rtl/icache_fill_ctrl.sv
// rtl/icache_fill_ctrl.sv - refill FSM: word counter, line base address, flush tracking, memory request
module icache_fill_ctrl
  import otter_icache_pkg::*;
#(
  parameter int WORDS_PER_LINE = 8,
  localparam int WB = wb_of(WORDS_PER_LINE)
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          start_i,
  input  logic [31:0]   start_base_i,
  input  logic          flush_i,
  input  logic          mem_ack_i,
  output state_e        state_o,
  output logic [WB-1:0] cnt_o,
  output logic [31:0]   base_o,
  output logic          wr_en_o,
  output logic          last_o,
  output logic          set_valid_o,
  output logic          mem_req_o,
  output logic [31:0]   mem_addr_o
);

  state_e        state_q, state_d;
  logic [WB-1:0] cnt_q, cnt_d;
  logic [31:0]   base_q, base_d;
  logic          flush_pend_q, flush_pend_d;
  logic          wr_en, last;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    base_d       = base_q;
    flush_pend_d = flush_pend_q;
    wr_en        = 1'b0;
    last         = 1'b0;
    case (state_q)
      READY: begin
        if (start_i) begin
          state_d      = FILL;
          cnt_d        = '0;
          base_d       = start_base_i;
          flush_pend_d = 1'b0;
        end
      end
      FILL: begin
        if (flush_i) flush_pend_d = 1'b1;
        if (mem_ack_i) begin
          wr_en = 1'b1;
          cnt_d = cnt_q + 1'b1;
          if (&cnt_q) begin
            last         = 1'b1;
            state_d      = READY;
            flush_pend_d = 1'b0;
          end
        end
      end
      default: state_d = READY;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= READY;
      cnt_q        <= '0;
      base_q       <= '0;
      flush_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      base_q       <= base_d;
      flush_pend_q <= flush_pend_d;
    end
  end

  // A flush arriving on the final ack also keeps the line invalid
  assign set_valid_o = last & ~flush_pend_q & ~flush_i;
  assign state_o     = state_q;
  assign cnt_o       = cnt_q;
  assign base_o      = base_q;
  assign wr_en_o     = wr_en;
  assign last_o      = last;
  assign mem_req_o   = (state_q == FILL);
  assign mem_addr_o  = base_q + {{(30 - WB){1'b0}}, cnt_q, 2'b00};

endmodule

// File: rtl/otter_icache.sv
// rtl/otter_icache.sv - direct-mapped read-only instruction cache; ICACHE_STATS_EN adds hit/miss counters
module otter_icache
  import otter_icache_pkg::*;
#(
  parameter int LINES          = 16,
  parameter int WORDS_PER_LINE = 8
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] PC_ADDR,
  input  logic        PC_RDEN,
  input  logic        FLUSH,
  output logic [31:0] IR,
  output logic        PC_STALL,
  output logic        MEM_REQ,
  output logic [31:0] MEM_ADDR,
  input  logic        MEM_ACK,
  input  logic [31:0] MEM_RDATA
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0] HIT_COUNT,
  output logic [31:0] MISS_COUNT
`endif
);

  localparam int WB = wb_of(WORDS_PER_LINE);
  localparam int IB = ib_of(LINES);
  localparam int TB = tb_of(LINES, WORDS_PER_LINE);

  logic [31:0]   data_q [LINES][WORDS_PER_LINE];
  logic [31:0]   data_d [LINES][WORDS_PER_LINE];
  logic [TB-1:0] tag_q  [LINES];
  logic [TB-1:0] tag_d  [LINES];
  logic [LINES-1:0] valid_q, valid_d;

  state_e        state;
  logic [WB-1:0] fill_cnt;
  logic [31:0]   fill_base;
  logic          wr_en, last, set_valid, hit, start;

  wire [WB-1:0] pc_word  = PC_ADDR[2 +: WB];
  wire [IB-1:0] pc_idx   = PC_ADDR[2 + WB +: IB];
  wire [TB-1:0] pc_tag   = PC_ADDR[31 -: TB];
  wire [IB-1:0] fill_idx = fill_base[2 + WB +: IB];
  wire [TB-1:0] fill_tag = fill_base[31 -: TB];
  wire          unused_bits = &{1'b0, PC_ADDR[1:0], fill_base[2 + WB - 1:0]};

  assign hit      = valid_q[pc_idx] && (tag_q[pc_idx] == pc_tag);
  assign start    = (state == READY) && PC_RDEN && !hit;
  assign PC_STALL = (state == FILL) || (PC_RDEN && !hit);
  assign IR       = data_q[pc_idx][pc_word];

  icache_fill_ctrl #(.WORDS_PER_LINE(WORDS_PER_LINE)) u_fill (
    .CLK          (CLK),
    .RST          (RST),
    .start_i      (start),
    .start_base_i ({PC_ADDR[31:2 + WB], {(WB + 2){1'b0}}}),
    .flush_i      (FLUSH),
    .mem_ack_i    (MEM_ACK),
    .state_o      (state),
    .cnt_o        (fill_cnt),
    .base_o       (fill_base),
    .wr_en_o      (wr_en),
    .last_o       (last),
    .set_valid_o  (set_valid),
    .mem_req_o    (MEM_REQ),
    .mem_addr_o   (MEM_ADDR)
  );

  always_comb begin
    data_d  = data_q;
    tag_d   = tag_q;
    valid_d = valid_q;
    if (wr_en) data_d[fill_idx][fill_cnt] = MEM_RDATA;
    if (last)  tag_d[fill_idx] = fill_tag;
    if (FLUSH) valid_d = '0;
    if (set_valid) valid_d[fill_idx] = 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (RST) valid_q <= '0;
    else     valid_q <= valid_d;
  end

  // Data and tags are qualified by valid, so they are left unreset
  always_ff @(posedge CLK) begin
    data_q <= data_d;
    tag_q  <= tag_d;
  end

`ifdef ICACHE_STATS_EN
  logic [31:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;

  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if ((state == READY) && PC_RDEN && hit && (hit_cnt_q != 32'hFFFF_FFFF))
      hit_cnt_d = hit_cnt_q + 32'd1;
    if (start && (miss_cnt_q != 32'hFFFF_FFFF))
      miss_cnt_d = miss_cnt_q + 32'd1;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign HIT_COUNT  = hit_cnt_q;
  assign MISS_COUNT = miss_cnt_q;
`endif

endmodule

// File: tb/tb_otter_icache.sv
// tb/tb_otter_icache.sv - randomized bench for otter_icache against a line-level cache model
module tb_otter_icache;

  localparam int LINES = 16;
  localparam int WPL   = 8;
  localparam int LINE_BYTES = WPL * 4;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [31:0] PC_ADDR = '0;
  logic        PC_RDEN = 1'b0;
  logic        FLUSH = 1'b0;
  logic        MEM_ACK = 1'b0;
  logic [31:0] IR, MEM_ADDR, MEM_RDATA;
  logic        PC_STALL, MEM_REQ;
`ifdef ICACHE_STATS_EN
  logic [31:0] HIT_COUNT, MISS_COUNT;
`endif

  // Backing memory holds each word's own address
  assign MEM_RDATA = MEM_ADDR;

  otter_icache #(.LINES(LINES), .WORDS_PER_LINE(WPL)) dut (
    .CLK(CLK), .RST(RST), .PC_ADDR(PC_ADDR), .PC_RDEN(PC_RDEN), .FLUSH(FLUSH),
    .IR(IR), .PC_STALL(PC_STALL), .MEM_REQ(MEM_REQ), .MEM_ADDR(MEM_ADDR),
    .MEM_ACK(MEM_ACK), .MEM_RDATA(MEM_RDATA)
`ifdef ICACHE_STATS_EN
    , .HIT_COUNT(HIT_COUNT), .MISS_COUNT(MISS_COUNT)
`endif
  );

  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Line-level reference model
  bit          started = 0;
  bit          m_valid [LINES];
  int unsigned m_tag   [LINES];
  bit          m_filling;
  int unsigned m_base;
  int          m_words;
  bit          m_flushed;
  int unsigned m_hits, m_misses;

  function automatic int unsigned line_of(input logic [31:0] a);
    return (a / LINE_BYTES) % LINES;
  endfunction

  function automatic int unsigned tag_of(input logic [31:0] a);
    return a / (LINE_BYTES * LINES);
  endfunction

  function automatic bit model_hit(input logic [31:0] a);
    return m_valid[line_of(a)] && (m_tag[line_of(a)] == tag_of(a));
  endfunction

  always @(posedge CLK) begin
    if (RST) begin
      foreach (m_valid[i]) m_valid[i] = 0;
      m_filling = 0; m_words = 0; m_flushed = 0; m_hits = 0; m_misses = 0;
      started = 1;
    end else if (started) begin
      if (m_filling) begin
        if (FLUSH) begin
          foreach (m_valid[i]) m_valid[i] = 0;
          m_flushed = 1;
        end
        if (MEM_ACK) begin
          m_words++;
          if (m_words == WPL) begin
            m_tag[line_of(m_base)] = tag_of(m_base);
            if (!m_flushed) m_valid[line_of(m_base)] = 1;
            m_filling = 0;
          end
        end
      end else begin
        bit h;
        h = model_hit(PC_ADDR);
        if (PC_RDEN && h && m_hits != 32'hFFFF_FFFF) m_hits++;
        if (FLUSH) foreach (m_valid[i]) m_valid[i] = 0;
        if (PC_RDEN && !h) begin
          m_filling = 1;
          m_base = PC_ADDR & ~(LINE_BYTES - 1);
          m_words = 0;
          m_flushed = 0;
          if (m_misses != 32'hFFFF_FFFF) m_misses++;
        end
      end
    end
  end

  always @(negedge CLK) begin
    if (started && !RST) begin
      bit exp_stall;
      exp_stall = m_filling || (PC_RDEN && !model_hit(PC_ADDR));
      check("pc_stall", {31'b0, PC_STALL}, {31'b0, exp_stall});
      check("mem_req", {31'b0, MEM_REQ}, {31'b0, m_filling});
      if (m_filling) check("mem_addr", MEM_ADDR, m_base + 4 * m_words);
      if (PC_RDEN && !exp_stall) check("ir", IR, PC_ADDR & 32'hFFFF_FFFC);
`ifdef ICACHE_STATS_EN
      check("hit_count", HIT_COUNT, m_hits);
      check("miss_count", MISS_COUNT, m_misses);
`endif
    end
  end

  // Memory responder: 0 = ack every cycle, 1 = every 3rd request cycle, 2 = random
  int ack_mode = 0;
  int req_run = 0;
  always @(negedge CLK) begin
    case (ack_mode)
      0: MEM_ACK = 1'b1;
      1: MEM_ACK = MEM_REQ && (req_run % 3 == 2);
      default: MEM_ACK = 1'($urandom_range(0, 1));
    endcase
    if (MEM_REQ) req_run++;
    else req_run = 0;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_req(input logic lvl, input string name);
    bit seen = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge CLK);
      if (MEM_REQ === lvl) seen = 1;
    end
    check({name, "_timeout"}, {31'b0, seen}, 32'd1);
  endtask

  task automatic wait_addr(input logic [31:0] a, input string name);
    bit seen = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge CLK);
      if (MEM_REQ === 1'b1 && MEM_ADDR === a) seen = 1;
    end
    check({name, "_timeout"}, {31'b0, seen}, 32'd1);
  endtask

  initial begin
    int          stall_cycles;
    int          req_cycles;
    bit          done;
    logic [31:0] addrs[$];

    // Reset state
    RST = 1; PC_RDEN = 0; PC_ADDR = 0; FLUSH = 0; ack_mode = 0;
    repeat (3) tick();
    RST = 0;
    @(negedge CLK);
    check("reset_mem_req", {31'b0, MEM_REQ}, 32'd0);
    check("reset_mem_addr", MEM_ADDR, 32'd0);
    check("reset_stall", {31'b0, PC_STALL}, 32'd0);

    // Cold miss at 0x0
    tick();
    PC_ADDR = 32'h0; PC_RDEN = 1;
    stall_cycles = 0; done = 0;
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge CLK);
      if (!PC_STALL) done = 1;
      else begin
        stall_cycles++;
        if (MEM_REQ) addrs.push_back(MEM_ADDR);
      end
    end
    check("cold_stall_cycles", stall_cycles, 32'd9);
    check("cold_burst_len", addrs.size(), 32'd8);
    foreach (addrs[i]) check("cold_burst_addr", addrs[i], 32'(i * 4));
    check("cold_ir", IR, 32'h0);
    for (int a = 4; a < 32; a += 4) begin
      tick();
      PC_ADDR = 32'(a);
      @(negedge CLK);
      check("seq_hit_stall", {31'b0, PC_STALL}, 32'd0);
      check("seq_hit_ir", IR, 32'(a));
    end
    tick();
    PC_RDEN = 0;
    @(negedge CLK);
`ifdef ICACHE_STATS_EN
    check("stats_hits_literal", HIT_COUNT, 32'd8);
    check("stats_miss_literal", MISS_COUNT, 32'd1);
`endif

    // Conflict miss at 0x200 on line 0
    tick();
    PC_ADDR = 32'h200; PC_RDEN = 1;
    @(negedge CLK);
    check("conflict_stall", {31'b0, PC_STALL}, 32'd1);
    @(negedge CLK);
    check("conflict_req", {31'b0, MEM_REQ}, 32'd1);
    check("conflict_addr", MEM_ADDR, 32'h200);
    wait_req(1'b0, "conflict_fill");
    check("conflict_ir", IR, 32'h200);
    tick();
    PC_ADDR = 32'h0;
    @(negedge CLK);
    check("refetch_0_miss", {31'b0, PC_STALL}, 32'd1);
    wait_req(1'b1, "refetch_start");
    wait_req(1'b0, "refetch_done");

    // Slow memory
    tick();
    ack_mode = 1;
    PC_ADDR = 32'h100;
    wait_req(1'b1, "slow_start");
    req_cycles = 1;
    done = 0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge CLK);
      if (MEM_REQ) req_cycles++;
      else done = 1;
    end
    check("slow_burst_cycles", req_cycles, 32'd24);
    for (int a = 'h100; a < 'h120; a += 4) begin
      tick();
      PC_ADDR = 32'(a);
      @(negedge CLK);
      check("slow_word_ir", IR, 32'(a));
    end

    // Flush during fill at word 3
    tick();
    ack_mode = 0;
    PC_ADDR = 32'h180;
    wait_addr(32'h188, "flush_word");
    tick();
    FLUSH = 1;
    tick();
    FLUSH = 0;
    wait_req(1'b0, "flush_fill_done");
    check("flush_refetch_stall", {31'b0, PC_STALL}, 32'd1);
    @(negedge CLK);
    check("flush_refill_addr", MEM_ADDR, 32'h180);
    wait_req(1'b0, "flush_refill_done");
    check("flush_refill_ir", IR, 32'h180);

    // Reset at word 5
    tick();
    PC_ADDR = 32'h280;
    wait_addr(32'h290, "rst_word");
    tick();
    RST = 1;
    tick();
    RST = 0;
    @(negedge CLK);
    check("rst_mid_fill_req", {31'b0, MEM_REQ}, 32'd0);
    check("rst_refetch_stall", {31'b0, PC_STALL}, 32'd1);
    wait_addr(32'h280, "rst_refill");
    wait_req(1'b0, "rst_refill_done");

    // Branch during fill
    tick();
    PC_ADDR = 32'h0;
    wait_addr(32'h08, "jump_word");
    tick();
    PC_ADDR = 32'h40;
    wait_req(1'b0, "jump_fill_done");
    check("jump_new_pc_miss", {31'b0, PC_STALL}, 32'd1);
    @(negedge CLK);
    check("jump_refill_addr", MEM_ADDR, 32'h40);
    wait_req(1'b0, "jump_refill_done");
    check("jump_ir", IR, 32'h40);
    tick();
    PC_ADDR = 32'h0;
    @(negedge CLK);
    check("jump_line0_valid", {31'b0, PC_STALL}, 32'd0);
    check("jump_line0_ir", IR, 32'h0);

    // Randomized traffic
    ack_mode = 2;
    for (int i = 0; i < 3000; i++) begin
      tick();
      RST     = ($urandom_range(0, 199) == 0);
      FLUSH   = ($urandom_range(0, 49) == 0);
      PC_RDEN = ($urandom_range(0, 9) != 0);
      case ($urandom_range(0, 3))
        0: PC_ADDR = (32'($urandom_range(0, 511)) << 2) | 32'($urandom_range(0, 3));
        1: PC_ADDR = (PC_ADDR + 32'd4) & 32'h7FF;
        default: ;
      endcase
    end
    tick();
    RST = 0; FLUSH = 0; PC_RDEN = 0;
    repeat (3) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
